// File: rtl/apb_intc.sv
// rtl/apb_intc.sv - APB interrupt controller with edge/level sources and claim/complete
// Fixed-priority arbitration (lowest index wins); IRQ_OUT/IRQ_ID are registered.
module apb_intc #(
   parameter int NumSrc = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic [5:0]        PADDR,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic [NumSrc-1:0] IRQ_IN,
   output logic              IRQ_OUT,
   output logic [4:0]        IRQ_ID
);

   localparam logic [5:0] ADDR_PENDING   = 6'h0;
   localparam logic [5:0] ADDR_ENABLE    = 6'h1;
   localparam logic [5:0] ADDR_TYPE      = 6'h2;
   localparam logic [5:0] ADDR_RAW       = 6'h3;
   localparam logic [5:0] ADDR_CLAIM     = 6'h4;
   localparam logic [5:0] ADDR_COMPLETE  = 6'h5;
   localparam logic [5:0] ADDR_INSERVICE = 6'h6;

   localparam logic [31:0] SRC_MASK = (NumSrc >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << NumSrc) - 32'd1);

   logic [31:0] irq_in_w;
   logic [31:0] irq_q;
   logic [31:0] pending;
   logic [31:0] enable;
   logic [31:0] src_type;
   logic [31:0] inservice;

   logic        wr;
   logic        rd;
   logic [31:0] rise;
   logic [31:0] eligible;
   logic        win_valid;
   logic [4:0]  win_id;
   logic        claim;
   logic [31:0] claim_mask;
   logic [31:0] w1c_mask;
   logic [31:0] edge_next;
   logic [31:0] pending_next;
   logic        complete;
   logic [31:0] complete_mask;

   assign irq_in_w = 32'(IRQ_IN) & SRC_MASK;
   assign PREADY   = 1'b1;

   assign wr = PSEL & PENABLE & PWRITE;
   assign rd = PSEL & PENABLE & ~PWRITE;

   assign rise      = irq_in_w & ~irq_q;
   assign eligible  = pending & enable & ~inservice;
   assign win_valid = |eligible;

   always_comb begin
      win_id = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id = 5'(i);
         end
      end
   end

   assign claim      = rd && (PADDR == ADDR_CLAIM) && win_valid;
   assign claim_mask = claim ? (32'd1 << win_id) : 32'd0;
   assign w1c_mask   = (wr && (PADDR == ADDR_PENDING)) ? PWDATA : 32'd0;

   // Edge bits: rise beats any clear landing in the same cycle.
   assign edge_next    = (pending & ~(w1c_mask | claim_mask)) | rise;
   assign pending_next = ((src_type & edge_next) | (~src_type & irq_in_w)) & SRC_MASK;

   assign complete      = wr && (PADDR == ADDR_COMPLETE) && (32'(PWDATA[4:0]) < NumSrc);
   assign complete_mask = complete ? (32'd1 << PWDATA[4:0]) : 32'd0;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         irq_q     <= 32'd0;
         pending   <= 32'd0;
         enable    <= 32'd0;
         src_type  <= 32'd0;
         inservice <= 32'd0;
         IRQ_OUT   <= 1'b0;
         IRQ_ID    <= 5'd0;
      end else begin
         irq_q     <= irq_in_w;
         pending   <= pending_next;
         inservice <= ((inservice & ~complete_mask) | claim_mask) & SRC_MASK;
         if (wr && (PADDR == ADDR_ENABLE)) begin
            enable <= PWDATA & SRC_MASK;
         end
         if (wr && (PADDR == ADDR_TYPE)) begin
            src_type <= PWDATA & SRC_MASK;
         end
         IRQ_OUT <= win_valid;
         IRQ_ID  <= win_id;
      end
   end

   always_comb begin
      PRDATA  = 32'd0;
      PSLVERR = 1'b0;
      if (PSEL && PENABLE && (PADDR > ADDR_INSERVICE)) begin
         PSLVERR = 1'b1;
      end
      if (rd) begin
         case (PADDR)
            ADDR_PENDING:   PRDATA = pending;
            ADDR_ENABLE:    PRDATA = enable;
            ADDR_TYPE:      PRDATA = src_type;
            ADDR_RAW:       PRDATA = irq_in_w;
            ADDR_CLAIM:     PRDATA = win_valid ? {1'b1, 26'd0, win_id} : 32'd0;
            ADDR_INSERVICE: PRDATA = inservice;
            default:        PRDATA = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_intc.sv
// tb/tb_apb_intc.sv - directed self-checking bench for apb_intc
module tb_apb_intc;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel;
   logic [5:0]  paddr;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [31:0] irq_in;
   logic        irq_out;
   logic [4:0]  irq_id;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rdata;
   logic        rerr;

   always #5 clk = ~clk;

   apb_intc #(.NumSrc(32)) dut (
      .PCLK    (clk),
      .PRESET  (rst),
      .PSEL    (psel),
      .PADDR   (paddr),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PWDATA  (pwdata),
      .PRDATA  (prdata),
      .PREADY  (pready),
      .PSLVERR (pslverr),
      .IRQ_IN  (irq_in),
      .IRQ_OUT (irq_out),
      .IRQ_ID  (irq_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic e);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1;
      d = prdata;
      e = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; psel = 1'b0; paddr = 6'd0; penable = 1'b0; pwrite = 1'b0;
      pwdata = 32'd0; irq_in = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_irq_out", {31'd0, irq_out}, 32'd0);
      chk("rst_irq_id", {27'd0, irq_id}, 32'd0);
      chk("pready", {31'd0, pready}, 32'd1);
      for (int i = 0; i <= 6; i++) begin
         apb_read(6'(i), rdata, rerr);
         chk($sformatf("rst_reg%0d", i), rdata, 32'd0);
         chk($sformatf("rst_err%0d", i), {31'd0, rerr}, 32'd0);
      end
      apb_read(6'h7, rdata, rerr);
      chk("unmapped_err", {31'd0, rerr}, 32'd1);
      chk("unmapped_data", rdata, 32'd0);

      // Edge source 0 pulse, claim
      apb_write(6'h2, 32'h1);
      apb_write(6'h1, 32'h1);
      @(negedge clk); irq_in[0] = 1'b1;
      @(negedge clk); irq_in[0] = 1'b0;
      chk("edge0_irq_lat", {31'd0, irq_out}, 32'd0);
      @(negedge clk);
      chk("edge0_irq_out", {31'd0, irq_out}, 32'd1);
      chk("edge0_irq_id", {27'd0, irq_id}, 32'd0);
      apb_read(6'h0, rdata, rerr);
      chk("edge0_pending", rdata, 32'h1);
      apb_read(6'h4, rdata, rerr);
      chk("edge0_claim", rdata, 32'h8000_0000);
      @(negedge clk);
      chk("edge0_irq_after_claim", {31'd0, irq_out}, 32'd0);
      apb_read(6'h0, rdata, rerr);
      chk("edge0_pending_after", rdata, 32'h0);
      apb_read(6'h6, rdata, rerr);
      chk("edge0_inservice", rdata, 32'h1);

      // Level sources 2 and 3, claim and complete
      apb_write(6'h1, 32'hC);
      @(negedge clk); irq_in[3:2] = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("lvl_irq_out", {31'd0, irq_out}, 32'd1);
      chk("lvl_irq_id2", {27'd0, irq_id}, 32'd2);
      apb_read(6'h3, rdata, rerr);
      chk("raw", rdata, 32'hC);
      apb_write(6'h3, 32'hFFFF_FFFF);
      apb_read(6'h3, rdata, rerr);
      chk("raw_ro", rdata, 32'hC);
      apb_read(6'h4, rdata, rerr);
      chk("lvl_claim", rdata, 32'h8000_0002);
      @(negedge clk);
      chk("lvl_irq_id3", {27'd0, irq_id}, 32'd3);
      apb_write(6'h5, 32'd2);
      @(negedge clk);
      chk("lvl_complete_id2", {27'd0, irq_id}, 32'd2);
      apb_read(6'h5, rdata, rerr);
      chk("complete_reads0", rdata, 32'd0);
      apb_read(6'h6, rdata, rerr);
      chk("lvl_inservice", rdata, 32'h1);

      // Disabled edge source 5 keeps pending
      irq_in = 32'd0;
      apb_write(6'h2, 32'h21);
      @(negedge clk); irq_in[5] = 1'b1;
      @(negedge clk); irq_in[5] = 1'b0;
      @(negedge clk);
      apb_read(6'h0, rdata, rerr);
      chk("en5_pending", rdata, 32'h20);
      chk("en5_irq_off", {31'd0, irq_out}, 32'd0);
      apb_write(6'h1, 32'h2C);
      @(negedge clk);
      chk("en5_irq_on", {31'd0, irq_out}, 32'd1);
      chk("en5_irq_id", {27'd0, irq_id}, 32'd5);
      apb_write(6'h0, 32'h20);
      @(negedge clk);
      chk("en5_w1c_irq", {31'd0, irq_out}, 32'd0);
      apb_read(6'h0, rdata, rerr);
      chk("en5_w1c_pending", rdata, 32'h0);

      // Rise and W1C of bit 1 on the same edge: set wins
      apb_write(6'h2, 32'h23);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h0; pwdata = 32'h2;
      @(negedge clk);
      penable = 1'b1; irq_in[1] = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; irq_in[1] = 1'b0;
      apb_read(6'h0, rdata, rerr);
      chk("setwins_pending", rdata, 32'h2);
      apb_write(6'h0, 32'h2);
      apb_read(6'h0, rdata, rerr);
      chk("w1c_alone", rdata, 32'h0);

      // Reset mid-operation
      apb_write(6'h5, 32'd0);
      @(negedge clk); irq_in[3:2] = 2'b11;
      @(negedge clk);
      @(negedge clk);
      apb_read(6'h4, rdata, rerr);
      chk("pre_rst_claim", rdata, 32'h8000_0002);
      @(negedge clk);
      chk("pre_rst_irq_out", {31'd0, irq_out}, 32'd1);
      chk("pre_rst_irq_id", {27'd0, irq_id}, 32'd3);
      apb_read(6'h6, rdata, rerr);
      chk("pre_rst_inservice", rdata, 32'h4);
      @(negedge clk);
      rst = 1'b1; irq_in = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_irq_out", {31'd0, irq_out}, 32'd0);
      chk("post_rst_irq_id", {27'd0, irq_id}, 32'd0);
      for (int i = 0; i <= 2; i++) begin
         apb_read(6'(i), rdata, rerr);
         chk($sformatf("post_rst_reg%0d", i), rdata, 32'd0);
      end
      apb_read(6'h6, rdata, rerr);
      chk("post_rst_inservice", rdata, 32'd0);
      apb_read(6'h4, rdata, rerr);
      chk("empty_claim", rdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_intc.md
Name: apb_intc

Overview:
- APB slave interrupt controller directly downstream of the APB peripheral subsystem.
- Consumes the 32-bit peripheral interrupt vector: UART rx/tx, GPIO combined and per-pin lines.
- Latches, masks and arbitrates the sources. Drives a single registered IRQ line plus source ID to the core.
- Provides claim/complete registers so software services one source at a time.

Parameters:
- NumSrc, 32, number of interrupt sources (1..32); bits at or above NumSrc read 0 and are unused.

Ports:
- PCLK  input  1  clock; the only clock.
- PRESET  input  1  reset, synchronous, active-high.
- PSEL  input  1  APB select.
- PADDR  input  6  word address (byte address [7:2]).
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, valid when PSEL&PENABLE&~PWRITE.
- PREADY  output  1  tied 1 (zero wait states).
- PSLVERR  output  1  error on unmapped word address during access phase.
- IRQ_IN  input  NumSrc  interrupt sources, synchronous to PCLK.
- IRQ_OUT  output  1  registered interrupt request to the core.
- IRQ_ID  output  5  registered ID of the highest-priority eligible source.

Behaviour:
- Reset (PRESET=1 at a PCLK edge) clears irq_q, PENDING, ENABLE, TYPE and INSERVICE, and sets IRQ_OUT=0 and IRQ_ID=0. PRDATA=0 and PSLVERR=0 when not accessed.
- Write strobe: wr = PSEL&PENABLE&PWRITE. Read strobe: rd = PSEL&PENABLE&~PWRITE. Setup phase (PENABLE=0) has no side effects.
- Register map (word index = PADDR):
  - 0x0 PENDING: read; write-1-to-clear, edge-type bits only.
  - 0x1 ENABLE: read/write.
  - 0x2 TYPE: read/write; 1 = rising-edge, 0 = level.
  - 0x3 RAW: read-only, current IRQ_IN.
  - 0x4 CLAIM: read-only with side effect.
  - 0x5 COMPLETE: write-only; reads 0.
  - 0x6 INSERVICE: read-only.
  - Any other index: PSLVERR=1 in the access phase, PRDATA=0, no state change.
  - Write to a read-only register: ignored, no error.
- Edge detect: irq_q <= IRQ_IN every cycle; rise = IRQ_IN & ~irq_q.
- Edge pending bit:
  - Set on rise.
  - Cleared by a PENDING W1C or by a claim of that ID.
  - If set and clear occur in the same cycle, set wins.
- Level pending bit: pending <= IRQ_IN each cycle. W1C has no effect.
- Eligible = PENDING & ENABLE & ~INSERVICE.
- Priority is fixed: the lowest index wins.
- Outputs registered each cycle: IRQ_OUT <= |eligible; IRQ_ID <= index of the lowest eligible bit, or 0 if none.
- Latency: a source rises before edge k, PENDING is set at edge k, and IRQ_OUT/IRQ_ID update at edge k+1.
- CLAIM read:
  - PRDATA = {valid, 26'b0, id}, where valid = |eligible and id = the combinational winner in that cycle.
  - If valid, at the end of the access phase: INSERVICE[id] <= 1, and PENDING[id] <= 0 if that source is edge type.
  - If not valid, PRDATA=0 and no state change.
  - One claim per access phase.
- COMPLETE write: INSERVICE[PWDATA[4:0]] <= 0.
  - ID >= NumSrc: ignored.
  - A completed level source still asserted re-raises IRQ_OUT on the next cycle.
- Simultaneous claim and complete of the same ID cannot occur (single APB port).
- While a source is in service, a new edge on it is still recorded in PENDING. It is not eligible until completed.
- Disabling a source (ENABLE=0) keeps PENDING intact; the source becomes eligible again when re-enabled.
- Reset mid-operation discards all pending and in-service state on that edge. An IRQ_IN level held through reset is seen as a rise on the first post-reset edge, because irq_q is 0.

Test Plan:
- Reset, then read every register: all 0. IRQ_OUT=0, IRQ_ID=0. Read of index 0x7 gives PSLVERR=1, PRDATA=0.
- TYPE=0x1, ENABLE=0x1, pulse IRQ_IN[0] for 1 cycle: PENDING=0x1 the next edge, IRQ_OUT=1 one edge later. CLAIM reads 0x80000000, then PENDING=0, INSERVICE=0x1, IRQ_OUT=0.
- ENABLE=0x0000000C, level sources 2 and 3 held high: IRQ_ID=2. CLAIM returns 0x80000002, and IRQ_ID then becomes 3. Write COMPLETE=2: source 2 is eligible again and IRQ_ID=2.
- Edge source 5, ENABLE bit 5=0, pulse IRQ_IN[5]: PENDING=0x20, IRQ_OUT=0. Set ENABLE bit 5: IRQ_OUT=1 within 2 cycles. W1C PENDING=0x20: IRQ_OUT=0.
- Rise on source 1 in the same cycle as a W1C of PENDING bit 1: PENDING bit 1 remains 1 (set wins).
- Assert PRESET while INSERVICE=0x4 and IRQ_OUT=1: all state returns to 0 on the next edge. CLAIM with nothing eligible returns 0x00000000.
